// File: rtl/serial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mac_ctrl
// Batch multiply-accumulate controller wrapped around an external serial
// multiplier. A batch of `len` operand pairs is pulled one at a time from an
// upstream valid/ready source. Each pair is handed to the multiplier, the
// product is added into a wide accumulator, and the total is published on
// `sum` with a single-cycle `sum_valid` pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start, len   start a batch of len pairs (sampled only while idle)
//   a_in, b_in   upstream operand pair, qualified by in_valid
//   in_valid     upstream pair valid
//   in_ready     pair accepted this cycle (only while fetching)
//   multiplicant, multiplier  registered operands driven to the multiplier
//   mult_rst     active-high multiplier reset (also clears its done level)
//   mult_en      one-cycle start pulse to the multiplier
//   product      multiplier result, valid while done is high
//   done         multiplier done level, held until mult_rst
//   sum          batch total, held until the next batch completes
//   sum_valid    one-cycle pulse when sum is updated
//   busy         high whenever the controller is not idle
//   count        products accumulated in the current batch
// ---------------------------------------------------------------------------
module serial_mac_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    localparam int PW   = 2*WIDTH,
    localparam int AW   = PW + CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] multiplicant,
    output logic [WIDTH-1:0] multiplier,
    output logic             mult_rst,
    output logic             mult_en,
    input  logic [PW-1:0]    product,
    input  logic             done,
    output logic [AW-1:0]    sum,
    output logic             sum_valid,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {IDLE, FETCH, ARM, LAUNCH, WAIT, FINISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);

    // All outputs are registered: each transition loads the output values
    // belonging to the state being entered, so they line up with `state`.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len_q        <= '0;
            acc          <= '0;
            sum          <= '0;
            count        <= '0;
            multiplicant <= '0;
            multiplier   <= '0;
            sum_valid    <= 1'b0;
            mult_en      <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            mult_rst     <= 1'b1;
        end else begin
            // Single-cycle pulses fall back to zero unless re-asserted below.
            sum_valid <= 1'b0;
            mult_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len != '0) begin
                            state    <= FETCH;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    // mult_rst stays high here, which clears the previous done.
                    if (in_valid) begin
                        multiplicant <= a_in;
                        multiplier   <= b_in;
                        in_ready     <= 1'b0;
                        mult_rst     <= 1'b0;
                        state        <= ARM;
                    end
                end
                ARM: begin
                    // One quiet cycle with the multiplier out of reset before
                    // the enable pulse.
                    mult_en <= 1'b1;
                    state   <= LAUNCH;
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // No timeout: the multiplier latency is unbounded.
                    if (done) begin
                        acc      <= acc + AW'(product);
                        count    <= count_inc;
                        mult_rst <= 1'b1;
                        if (count_inc == len_q) begin
                            state    <= FINISH;
                        end else begin
                            state    <= FETCH;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    sum       <= acc;
                    sum_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    mult_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_mac_ctrl
// Drives batches into serial_mac_ctrl with a behavioural serial multiplier
// attached, and compares batch sums, counts and multiplier handshakes with a
// reference computed from the operand lists by plain arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_mac_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int PW    = 2*WIDTH;
    localparam int AW    = PW + CNT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [WIDTH-1:0] a_in = '0, b_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] multiplicant, multiplier;
    logic             mult_rst, mult_en;
    logic [PW-1:0]    product = '0;
    logic             done = 1'b0;
    logic [AW-1:0]    sum;
    logic             sum_valid, busy;
    logic [CNT_W-1:0] count;

    int vectors = 0;
    int errors  = 0;

    serial_mac_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicant(multiplicant), .multiplier(multiplier),
        .mult_rst(mult_rst), .mult_en(mult_en),
        .product(product), .done(done),
        .sum(sum), .sum_valid(sum_valid), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural serial multiplier ----------------
    int               m_lat = 3;
    bit               m_rand_lat = 1'b0;
    logic             m_busy = 1'b0;
    int               m_cd = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0;

    always @(posedge clk) begin
        if (mult_rst) begin
            done    <= 1'b0;
            product <= PW'($urandom);
            m_busy  <= 1'b0;
        end else if (mult_en) begin
            m_busy <= 1'b1;
            m_cd   <= (m_rand_lat ? int'($urandom_range(1, 12)) : m_lat) - 1;
            m_a    <= multiplicant;
            m_b    <= multiplier;
        end else if (m_busy) begin
            if (m_cd == 0) begin
                done    <= 1'b1;
                product <= PW'(m_a) * PW'(m_b);
                m_busy  <= 1'b0;
            end else begin
                m_cd    <= m_cd - 1;
                product <= PW'($urandom);
            end
        end
    end

    // ---------------- handshake monitor (samples 1 after posedge) ----------
    int               en_cnt = 0, sv_cnt = 0, viol = 0;
    logic [WIDTH-1:0] en_a [0:31];
    logic [WIDTH-1:0] en_b [0:31];
    logic             h1_rst = 1'b1, h2_rst = 1'b1, h1_en = 1'b0;
    logic             p_ready = 1'b0, p_reset = 1'b0, p_sv = 1'b0;
    logic [WIDTH-1:0] p_a = '0, p_b = '0;

    always @(posedge clk) begin
        #1;
        if (reset && p_reset) begin
            if (mult_en) begin
                // enable must follow a reset cycle and then one quiet cycle
                if (!(h2_rst && !h1_rst && !h1_en)) viol++;
                if (en_cnt < 32) begin
                    en_a[en_cnt] = multiplicant;
                    en_b[en_cnt] = multiplier;
                end
                en_cnt++;
            end
            if (in_ready && (!mult_rst || mult_en)) viol++;
            if ((multiplicant !== p_a || multiplier !== p_b) && !p_ready) viol++;
            if (sum_valid) begin
                sv_cnt++;
                if (p_sv || busy) viol++;
            end
        end
        h2_rst  = h1_rst;
        h1_rst  = mult_rst;
        h1_en   = mult_en;
        p_ready = in_ready;
        p_reset = reset;
        p_sv    = sum_valid;
        p_a     = multiplicant;
        p_b     = multiplier;
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] pa [0:15];
    logic [WIDTH-1:0] pb [0:15];

    function automatic int exp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(pa[i]) * int'(pb[i]);
        return s;
    endfunction

    // Runs a batch of n pairs from pa/pb; returns at the negedge where
    // sum_valid is seen, or ok=0 if a bounded wait expired.
    task automatic feed_batch(input int n, input int max_gap, output bit ok);
        bit got;
        ok = 1'b1;
        @(negedge clk); start = 1'b1; len = CNT_W'(n);
        @(negedge clk); start = 1'b0; len = CNT_W'($urandom);
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (in_ready) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin ok = 1'b0; return; end
            repeat ($urandom_range(0, max_gap)) begin
                a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
                @(negedge clk);
            end
            a_in = pa[i]; b_in = pb[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
        end
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (sum_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        ok = got;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, in_ready, mult_rst, mult_en, sum_valid} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00100", {busy, in_ready, mult_rst, mult_en, sum_valid});
        end
        vectors++;
        if (sum !== '0 || count !== '0 || multiplicant !== '0 || multiplier !== '0) begin
            errors++;
            $display("FAIL reset_data: sum=%0d count=%0d ops=%0d,%0d expected all 0", sum, count, multiplicant, multiplier);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        pa[0] = 4'd3; pb[0] = 4'd5; m_lat = 10; m_rand_lat = 1'b0;
        en_cnt = 0; sv_cnt = 0;
        feed_batch(1, 0, ok);
        vectors++;
        if (!ok || sum !== AW'(15) || count !== CNT_W'(1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL single: ok=%0d sum=%0d count=%0d busy=%0d expected 1,15,1,0", ok, sum, count, busy);
        end
        vectors++;
        if (en_cnt !== 1 || en_a[0] !== 4'd3 || en_b[0] !== 4'd5) begin
            errors++;
            $display("FAIL single_en: pulses=%0d ops=%0d,%0d expected 1,3,5", en_cnt, en_a[0], en_b[0]);
        end
        @(negedge clk);
        vectors++;
        if (sum_valid !== 1'b0 || sv_cnt !== 1 || sum !== AW'(15)) begin
            errors++;
            $display("FAIL single_pulse: sum_valid=%0d pulses=%0d sum=%0d expected 0,1,15", sum_valid, sv_cnt, sum);
        end
    endtask

    task automatic test_three();
        bit ok;
        for (int i = 0; i < 3; i++) begin pa[i] = 4'd15; pb[i] = 4'd15; end
        m_lat = 4; en_cnt = 0;
        feed_batch(3, 1, ok);
        vectors++;
        if (!ok || sum !== AW'(675) || count !== CNT_W'(3) || en_cnt !== 3) begin
            errors++;
            $display("FAIL three: ok=%0d sum=%0d count=%0d pulses=%0d expected 1,675,3,3", ok, sum, count, en_cnt);
        end
    endtask

    task automatic test_full();
        bit ok;
        for (int i = 0; i < 15; i++) begin pa[i] = 4'd15; pb[i] = 4'd15; end
        m_lat = 2; en_cnt = 0;
        feed_batch(15, 0, ok);
        vectors++;
        if (!ok || sum !== AW'(3375) || count !== CNT_W'(15) || en_cnt !== 15) begin
            errors++;
            $display("FAIL full: ok=%0d sum=%0d count=%0d pulses=%0d expected 1,3375,15,15", ok, sum, count, en_cnt);
        end
    endtask

    task automatic test_len0();
        en_cnt = 0;
        @(negedge clk); start = 1'b1; len = '0;
        @(negedge clk); start = 1'b0;
        vectors++;
        if (sum_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL len0_finish: sum_valid=%0d busy=%0d expected 0,1", sum_valid, busy);
        end
        @(negedge clk);
        vectors++;
        if (sum_valid !== 1'b1 || sum !== '0 || count !== '0 || busy !== 1'b0 || en_cnt !== 0) begin
            errors++;
            $display("FAIL len0: sv=%0d sum=%0d count=%0d busy=%0d pulses=%0d expected 1,0,0,0,0",
                     sum_valid, sum, count, busy, en_cnt);
        end
    endtask

    task automatic test_stall();
        bit got;
        logic [WIDTH-1:0] oa, ob;
        m_lat = 3; en_cnt = 0;
        @(negedge clk); start = 1'b1; len = CNT_W'(1);
        @(negedge clk); start = 1'b0;
        oa = multiplicant; ob = multiplier;
        for (int c = 0; c < 5; c++) begin
            a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || mult_rst !== 1'b1 || mult_en !== 1'b0 ||
                multiplicant !== oa || multiplier !== ob) begin
                errors++;
                $display("FAIL stall[%0d]: rdy=%0d rst=%0d en=%0d ops=%0d,%0d expected 1,1,0,%0d,%0d",
                         c, in_ready, mult_rst, mult_en, multiplicant, multiplier, oa, ob);
            end
        end
        a_in = 4'd7; b_in = 4'd9; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sum_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got || sum !== AW'(63) || en_cnt !== 1) begin
            errors++;
            $display("FAIL stall_sum: got=%0d sum=%0d pulses=%0d expected 1,63,1", got, sum, en_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok, got;
        m_lat = 20; en_cnt = 0;
        @(negedge clk); start = 1'b1; len = CNT_W'(2);
        @(negedge clk); start = 1'b0;
        a_in = 4'd6; b_in = 4'd7; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (en_cnt == 1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        sv_cnt = 0;
        reset = 1'b0;
        #1;
        vectors++;
        if (!got || {busy, in_ready, mult_rst, mult_en, sum_valid} !== 5'b00100 ||
            sum !== '0 || count !== '0 || multiplicant !== '0 || multiplier !== '0) begin
            errors++;
            $display("FAIL reset_wait: launched=%0d ctrl=%b sum=%0d count=%0d ops=%0d,%0d expected 1,00100,0,0,0,0",
                     got, {busy, in_ready, mult_rst, mult_en, sum_valid}, sum, count, multiplicant, multiplier);
        end
        @(negedge clk); reset = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (sv_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: sum_valid pulses=%0d busy=%0d expected 0,0", sv_cnt, busy);
        end
        pa[0] = 4'd2; pb[0] = 4'd3; pa[1] = 4'd4; pb[1] = 4'd5; m_lat = 5;
        feed_batch(2, 0, ok);
        vectors++;
        if (!ok || sum !== AW'(26) || count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL reset_resume: ok=%0d sum=%0d count=%0d expected 1,26,2", ok, sum, count);
        end
    endtask

    task automatic test_start_in_wait();
        bit ok, got;
        for (int i = 0; i < 3; i++) begin
            pa[i] = WIDTH'($urandom); pb[i] = WIDTH'($urandom);
        end
        m_lat = 8; en_cnt = 0;
        got = 1'b0;
        fork
            feed_batch(3, 0, ok);
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (en_cnt == 1) begin got = 1'b1; break; end
                end
                @(negedge clk); start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
        join
        vectors++;
        if (!ok || !got || sum !== AW'(exp_sum(3)) || count !== CNT_W'(3) || en_cnt !== 3) begin
            errors++;
            $display("FAIL start_ignored: ok=%0d sum=%0d count=%0d pulses=%0d expected 1,%0d,3,3",
                     ok && got, sum, count, en_cnt, exp_sum(3));
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_no_retrigger: busy=%0d in_ready=%0d expected 0,0", busy, in_ready);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, bad;
        m_rand_lat = 1'b1;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) begin
                pa[i] = WIDTH'($urandom); pb[i] = WIDTH'($urandom);
            end
            en_cnt = 0;
            feed_batch(n, 3, ok);
            vectors++;
            if (!ok || sum !== AW'(exp_sum(n)) || count !== CNT_W'(n) || en_cnt !== n) begin
                errors++;
                $display("FAIL random[%0d]: ok=%0d sum=%0d count=%0d pulses=%0d expected 1,%0d,%0d,%0d",
                         b, ok, sum, count, en_cnt, exp_sum(n), n, n);
            end
            bad = 0;
            for (int i = 0; i < n; i++)
                if (en_a[i] !== pa[i] || en_b[i] !== pb[i]) bad++;
            vectors++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_ops[%0d]: %0d launched pairs differ from supplied pairs, expected 0", b, bad);
            end
        end
        m_rand_lat = 1'b0;
    endtask

    task automatic test_protocol();
        vectors++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol: %0d handshake violations observed, expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_full();
        test_len0();
        test_stall();
        test_reset_in_wait();
        test_start_in_wait();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_mac_ctrl.md
SERIAL_MAC_CTRL -- requirements
Module: serial_mac_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width of the attached serialMultiplier.
REQ-002 Parameter: CNT_W, default 4, width of batch length and product counter.
REQ-003 Derived: PW = 2*WIDTH (product width); AW = PW+CNT_W (accumulator width).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a batch; sampled only in IDLE.
REQ-007 len  in  CNT_W  number of operand pairs in the batch, sampled with start.
REQ-008 a_in, b_in  in  WIDTH each  upstream operand pair.
REQ-009 in_valid  in  1  upstream pair valid.
REQ-010 in_ready  out  1  block accepts the pair this cycle.
REQ-011 multiplicant, multiplier  out  WIDTH each  registered operands to the multiplier.
REQ-012 mult_rst  out  1  active-high reset to the multiplier.
REQ-013 mult_en  out  1  one-cycle Enable pulse to the multiplier.
REQ-014 product  in  PW  multiplier result.
REQ-015 done  in  1  multiplier done level; held high until mult_rst.
REQ-016 sum  out  AW  batch sum, held until the next batch completes.
REQ-017 sum_valid  out  1  one-cycle pulse when sum is updated.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 count  out  CNT_W  products accumulated in the current batch.

Function
REQ-020 FSM states: IDLE, FETCH, ARM, LAUNCH, WAIT, FINISH.
REQ-021 IDLE: start=1 -> latch len, acc=0, count=0; next FETCH if len!=0, FINISH if len==0.
REQ-022 start outside IDLE is ignored; len changes outside IDLE are ignored.
REQ-023 FETCH: in_ready=1, mult_rst=1; in_valid=1 -> multiplicant<=a_in, multiplier<=b_in, next ARM; else stay.
REQ-024 in_ready is 0 in every state but FETCH; exactly one pair is consumed per product.
REQ-025 ARM: mult_rst=0, mult_en=0, one cycle, next LAUNCH.
REQ-026 LAUNCH: mult_rst=0, mult_en=1 for exactly this cycle, next WAIT.
REQ-027 WAIT: mult_rst=0; done=1 -> acc<=acc+product, count<=count+1; next FINISH if count+1==len, else FETCH.
REQ-028 WAIT is unbounded; no timeout.
REQ-029 multiplicant and multiplier stay stable from ARM through WAIT.
REQ-030 mult_rst=1 in IDLE, FETCH and FINISH, so done is cleared at least one cycle before each WAIT.
REQ-031 FINISH: sum<=acc, sum_valid=1 for one cycle, next IDLE.
REQ-032 Addition is unsigned, product zero-extended to AW; no wrap at 15 x 225 = 3375 (defaults).
REQ-033 count holds its final value in IDLE until the next start clears it.

Reset
REQ-034 On reset low, immediately and from any state:
  - state=IDLE; acc, sum, count, multiplicant, multiplier = 0
  - sum_valid, mult_en, in_ready, busy = 0
  - mult_rst = 1
REQ-035 A reset during a batch discards it; no sum_valid is produced for that batch.
REQ-036 Normal operation resumes on the first rising clk edge after reset is released.

Verification
REQ-037 len=1, pair (3,5), done rises 10 cycles after mult_en, product=15 -> sum=15, sum_valid one cycle, count=1, busy low next cycle.
REQ-038 len=3, pairs (15,15) x3 -> sum=675; exactly 3 mult_en pulses, each preceded by mult_rst=1 and then one mult_rst=0 ARM cycle.
REQ-039 len=15, all pairs (15,15) -> sum=3375, no wrap; len=0 -> sum=0, sum_valid 2 cycles after start, no mult_en.
REQ-040 in_valid low for 5 cycles in FETCH -> in_ready stays 1, mult_rst stays 1, no mult_en, operands unchanged.
REQ-041 reset pulsed low in WAIT of a len=2 batch -> all outputs at reset values, no sum_valid; a new len=2 batch (2,3),(4,5) then gives sum=26.
REQ-042 start pulsed during WAIT -> ignored; batch completes with the correct sum and the len latched at the original start.
